ex_operand_stage: RTL

//  ID/EX pipeline register plus operand forwarding, directly upstream of the EX-stage ALU.

---
 rtl/ex_operand_if.sv | 82 ++++++++
 rtl/ex_operand_stage.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/ex_operand_if.sv
// ---------------------------------------------------------------------------
// ex_operand_if
// Bundle of everything that crosses the ID/EX boundary around the EX-stage
// operand register, apart from clock and reset.
//
// The pipeline control, decoded ID fields and forwarding sources flow into
// the stage. The ALU operands and EX-slot bookkeeping flow out of it.
//
// Modports:
//   master : the ID stage / hazard unit side. Drives stall, flush, id_*,
//            mem_* and wb_*, and observes alu_* and ex_*.
//   slave  : the operand stage itself (ex_operand_stage).
//
// Signals:
//   stall, flush           pipeline control
//   id_valid .. id_reg_write decoded instruction fields from ID
//   mem_reg_write/rd/res   EX/MEM forwarding source
//   wb_reg_write/rd/data   MEM/WB forwarding source
//   alu_a, alu_b, alu_op   ALU operands and 4-bit operation {fun7[5],fun3}
//   ex_rs2_val             forwarded rs2, used as store data
//   ex_pc, ex_rd           registered PC and destination register
//   ex_valid               EX slot holds a real instruction
//   ex_reg_write           registered reg_write qualified by ex_valid
// ---------------------------------------------------------------------------
interface ex_operand_if #(
  parameter int XLEN = 32,
  parameter int RW   = 5
);
  // Pipeline control
  logic            stall;
  logic            flush;

  // Decoded ID-stage instruction
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [RW-1:0]   id_rs1;
  logic [RW-1:0]   id_rs2;
  logic [RW-1:0]   id_rd;
  logic [2:0]      id_fun3;
  logic            id_fun7b5;
  logic            id_use_imm;
  logic            id_reg_write;

  // Forwarding sources
  logic            mem_reg_write;
  logic [RW-1:0]   mem_rd;
  logic [XLEN-1:0] mem_res;
  logic            wb_reg_write;
  logic [RW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;

  // EX-stage outputs
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] ex_rs2_val;
  logic [XLEN-1:0] ex_pc;
  logic [RW-1:0]   ex_rd;
  logic            ex_valid;
  logic            ex_reg_write;

  modport master (
    output stall, flush,
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
    output id_rs1, id_rs2, id_rd, id_fun3, id_fun7b5, id_use_imm, id_reg_write,
    output mem_reg_write, mem_rd, mem_res,
    output wb_reg_write, wb_rd, wb_data,
    input  alu_a, alu_b, alu_op, ex_rs2_val, ex_pc, ex_rd, ex_valid, ex_reg_write
  );

  modport slave (
    input  stall, flush,
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
    input  id_rs1, id_rs2, id_rd, id_fun3, id_fun7b5, id_use_imm, id_reg_write,
    input  mem_reg_write, mem_rd, mem_res,
    input  wb_reg_write, wb_rd, wb_data,
    output alu_a, alu_b, alu_op, ex_rs2_val, ex_pc, ex_rd, ex_valid, ex_reg_write
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ---------------------------------------------------------------------------
// ex_operand_stage
// ID/EX pipeline register with operand forwarding, sitting directly in front
// of the EX-stage ALU.
//
// Each cycle the decoded ID fields are latched. The stage then forms the
// ALU operands A and B, and the 4-bit ALU operation {fun7[5], fun3}. RAW
// hazards against the EX/MEM and MEM/WB stages are resolved by forwarding.
// A stall holds the slot, and a flush loads a bubble.
//
// Update priority on each rising edge is rst > flush > stall > load.
// Reset and flush both leave an all-zero bubble, so ex_valid=0, alu_op=0000
// and alu_a=alu_b=0.
//
// Configuration macro:
//   EXSTAGE_FWD_EN  When defined, builds the forwarding muxes and refreshes
//                   the held operands during a stall. When undefined, the
//                   operands come straight from the registered regfile data
//                   and the mem_*/wb_* inputs are ignored, so the hazard unit
//                   has to stall until the producer has written back.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   ex_operand_if.slave carrying stall/flush, the id_* fields, the
//         mem_*/wb_* forwarding sources and the alu_*/ex_* outputs
// ---------------------------------------------------------------------------
module ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input logic         clk,
  input logic         rst,
  ex_operand_if.slave bus
);

  // Registered ID/EX slot
  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;
  logic [RW-1:0]   rs1_q;
  logic [RW-1:0]   rs2_q;
  logic [RW-1:0]   rd_q;
  logic [3:0]      alu_op_q;
  logic            use_imm_q;
  logic            reg_write_q;

  // Operands after forwarding
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // ALU operation decoded from the ID fields
  logic [3:0]      id_alu_op;

  // For I-type instructions, bit 30 is part of the immediate. It only means
  // "arithmetic" for the shift-right group (fun3=101). Masking it elsewhere
  // keeps addi with a negative immediate from being decoded as sub, and keeps
  // slli from becoming op 1001.
  always_comb begin
    id_alu_op = {bus.id_fun7b5 & (~bus.id_use_imm | (bus.id_fun3 == 3'b101)),
                 bus.id_fun3};
  end

`ifdef EXSTAGE_FWD_EN
  // EX/MEM is younger than MEM/WB, so it wins when both target the same
  // register. x0 is never forwarded, because writes to it are discarded.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (rs1_q != '0 && bus.mem_reg_write && bus.mem_rd == rs1_q) begin
      fwd_rs1 = bus.mem_res;
    end else if (rs1_q != '0 && bus.wb_reg_write && bus.wb_rd == rs1_q) begin
      fwd_rs1 = bus.wb_data;
    end
  end

  always_comb begin
    fwd_rs2 = rs2_data_q;
    if (rs2_q != '0 && bus.mem_reg_write && bus.mem_rd == rs2_q) begin
      fwd_rs2 = bus.mem_res;
    end else if (rs2_q != '0 && bus.wb_reg_write && bus.wb_rd == rs2_q) begin
      fwd_rs2 = bus.wb_data;
    end
  end
`else
  // Without forwarding the operands come straight from the slot. The source
  // indices and the forwarding inputs are then deliberately left unused.
  assign fwd_rs1 = rs1_data_q;
  assign fwd_rs2 = rs2_data_q;

  logic unused_fwd;
  assign unused_fwd = ^{rs1_q, rs2_q,
                        bus.mem_reg_write, bus.mem_rd, bus.mem_res,
                        bus.wb_reg_write, bus.wb_rd, bus.wb_data};
`endif

  // Slot update. During a stall, the operand data is rewritten with its
  // forwarded value. A producer that retires from MEM/WB while we are held
  // would otherwise vanish before the stall releases. Without forwarding,
  // fwd_rsN equals the register, so this write is a plain hold.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alu_op_q    <= 4'b0000;
      use_imm_q   <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (bus.stall) begin
      rs1_data_q  <= fwd_rs1;
      rs2_data_q  <= fwd_rs2;
    end else begin
      valid_q     <= bus.id_valid;
      pc_q        <= bus.id_pc;
      rs1_data_q  <= bus.id_rs1_data;
      rs2_data_q  <= bus.id_rs2_data;
      imm_q       <= bus.id_imm;
      rs1_q       <= bus.id_rs1;
      rs2_q       <= bus.id_rs2;
      rd_q        <= bus.id_rd;
      alu_op_q    <= id_alu_op;
      use_imm_q   <= bus.id_use_imm;
      reg_write_q <= bus.id_reg_write;
    end
  end

  // Outputs
  assign bus.alu_a        = fwd_rs1;
  assign bus.alu_b        = use_imm_q ? imm_q : fwd_rs2;
  assign bus.alu_op       = alu_op_q;
  assign bus.ex_rs2_val   = fwd_rs2;
  assign bus.ex_pc        = pc_q;
  assign bus.ex_rd        = rd_q;
  assign bus.ex_valid     = valid_q;
  assign bus.ex_reg_write = reg_write_q & valid_q;

endmodule
